csr_trap_ctrl: RTL and testbench

- Machine-mode trap sequencer for the rv32im core.
- On an exception, interrupt or MRET it takes the pipeline's CSR write port and the csrfile read port. It then updates mepc/mcause/mtval/mstatus one CSR per cycle.
- It computes the redirect PC from mtvec/mepc and pulses a redirect to fetch.
- It sits directly upstream of csrfile, muxed with the WB write port and the ID read port; it owns both ports while busy_o=1.

---
 rtl/csr_pkg.sv | 63 ++++++
 rtl/csr_trap_ctrl_arbiter.sv | 34 +++
 rtl/csr_trap_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// mstatus/mie bit positions, interrupt cause codes, request kinds and the
// sequencer state encoding.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;
    localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;

    typedef enum logic [1:0] {
        KIND_EXC,
        KIND_MRET,
        KIND_IRQ_EXT,
        KIND_IRQ_TIMER
    } trap_kind_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_TVEC,
        S_RD_EPC,
        S_RD_STAT,
        S_WR_EPC,
        S_WR_CAUSE,
        S_WR_TVAL,
        S_WR_STAT,
        S_REDIR
    } trap_state_e;

    // mstatus on trap entry: stack MIE into MPIE, disable, return to M-mode.
    function automatic logic [31:0] trap_status(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // mstatus on MRET: restore MIE from MPIE, set MPIE, keep MPP at M.
    function automatic logic [31:0] mret_status(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/csr_trap_ctrl_arbiter.sv
// trap_arbiter: combinational request priority and interrupt gating.
// Priority is exception > MRET > external irq > timer irq; interrupts need
// the global MIE shadow plus their own enable shadow.
module trap_arbiter
    import csr_pkg::*;
(
    input  logic       idle_i,
    input  logic       exc_valid_i,
    input  logic       mret_valid_i,
    input  logic       irq_ext_i,
    input  logic       irq_timer_i,
    input  logic       sh_mie_i,
    input  logic       sh_meie_i,
    input  logic       sh_mtie_i,
    output logic       accept_o,
    output trap_kind_e kind_o
);

    logic ext_ok;
    logic tmr_ok;

    // Pick the highest-priority eligible request; accept only from IDLE.
    always_comb begin
        ext_ok = irq_ext_i & sh_mie_i & sh_meie_i;
        tmr_ok = irq_timer_i & sh_mie_i & sh_mtie_i;
        kind_o = KIND_EXC;
        if (exc_valid_i)       kind_o = KIND_EXC;
        else if (mret_valid_i) kind_o = KIND_MRET;
        else if (ext_ok)       kind_o = KIND_IRQ_EXT;
        else if (tmr_ok)       kind_o = KIND_IRQ_TIMER;
        accept_o = idle_i & (exc_valid_i | mret_valid_i | ext_ok | tmr_ok);
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode trap/MRET sequencer. Owns the csrfile read and
// write ports while busy and steps one CSR access per cycle, then pulses a
// fetch redirect. Optional macro MTVEC_VECTORED_EN enables vectored mtvec
// mode for interrupt traps.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            exc_valid_i,
    input  logic [3:0]      exc_cause_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_valid_i,
    input  logic            irq_ext_i,
    input  logic            irq_timer_i,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic            wb_csr_we_i,
    input  logic [11:0]     wb_csr_waddr_i,
    input  logic [XLEN-1:0] wb_csr_wdata_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            busy_o,
    output logic [11:0]     csr_raddr_o,
    output logic            csr_we_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    trap_state_e     state_q, state_d;
    trap_kind_e      kind_q;
    trap_kind_e      acc_kind;
    logic            accept;
    logic [XLEN-1:0] pc_q;
    logic [3:0]      cause_q;
    logic [XLEN-1:0] tval_q;
    logic [XLEN-1:0] tvec_q;     // mtvec for traps, mepc for MRET
    logic [XLEN-1:0] status_q;
    logic            sh_mie_q, sh_mie_d;
    logic            sh_meie_q, sh_meie_d;
    logic            sh_mtie_q, sh_mtie_d;
    logic            is_irq;
    logic [XLEN-1:0] trap_target;
    logic            unused_bits;

    trap_arbiter u_arb (
        .idle_i       (state_q == S_IDLE),
        .exc_valid_i  (exc_valid_i),
        .mret_valid_i (mret_valid_i),
        .irq_ext_i    (irq_ext_i),
        .irq_timer_i  (irq_timer_i),
        .sh_mie_i     (sh_mie_q),
        .sh_meie_i    (sh_meie_q),
        .sh_mtie_i    (sh_mtie_q),
        .accept_o     (accept),
        .kind_o       (acc_kind)
    );

    assign is_irq = (kind_q == KIND_IRQ_EXT) || (kind_q == KIND_IRQ_TIMER);

    // Bits that are deliberately ignored (alignment bits, non-shadowed data).
    assign unused_bits = ^{wb_csr_wdata_i, pc_q[1:0], tvec_q[1:0]};

    // Redirect target for traps: mtvec base, optionally offset by cause.
    always_comb begin
        trap_target = {tvec_q[XLEN-1:2], 2'b00};
`ifdef MTVEC_VECTORED_EN
        if (is_irq && (tvec_q[1:0] == 2'b01))
            trap_target = {tvec_q[XLEN-1:2], 2'b00} + {{(XLEN-6){1'b0}}, cause_q, 2'b00};
`endif
    end

    // Next state and CSR port drive; ports idle at zero outside their states.
    always_comb begin
        state_d          = state_q;
        busy_o           = (state_q != S_IDLE);
        csr_raddr_o      = '0;
        csr_we_o         = 1'b0;
        csr_waddr_o      = '0;
        csr_wdata_o      = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = (acc_kind == KIND_MRET) ? S_RD_EPC : S_RD_TVEC;
            end
            S_RD_TVEC: begin
                csr_raddr_o = CSR_MTVEC;
                state_d     = S_RD_STAT;
            end
            S_RD_EPC: begin
                csr_raddr_o = CSR_MEPC;
                state_d     = S_RD_STAT;
            end
            S_RD_STAT: begin
                csr_raddr_o = CSR_MSTATUS;
                state_d     = (kind_q == KIND_MRET) ? S_WR_STAT : S_WR_EPC;
            end
            S_WR_EPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = {pc_q[XLEN-1:2], 2'b00};
                state_d     = S_WR_CAUSE;
            end
            S_WR_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = {is_irq, {(XLEN-5){1'b0}}, cause_q};
                state_d     = S_WR_TVAL;
            end
            S_WR_TVAL: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MTVAL;
                csr_wdata_o = tval_q;
                state_d     = S_WR_STAT;
            end
            S_WR_STAT: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = (kind_q == KIND_MRET) ? mret_status(status_q)
                                                    : trap_status(status_q);
                state_d     = S_REDIR;
            end
            S_REDIR: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = (kind_q == KIND_MRET) ? {tvec_q[XLEN-1:2], 2'b00}
                                                         : trap_target;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shadow tracking of MIE/MEIE/MTIE; our own write port wins over WB.
    always_comb begin
        sh_mie_d  = sh_mie_q;
        sh_meie_d = sh_meie_q;
        sh_mtie_d = sh_mtie_q;
        if (wb_csr_we_i && (wb_csr_waddr_i == CSR_MSTATUS))
            sh_mie_d = wb_csr_wdata_i[MSTATUS_MIE];
        if (wb_csr_we_i && (wb_csr_waddr_i == CSR_MIE)) begin
            sh_meie_d = wb_csr_wdata_i[MIE_MEIE];
            sh_mtie_d = wb_csr_wdata_i[MIE_MTIE];
        end
        if (csr_we_o && (csr_waddr_o == CSR_MSTATUS))
            sh_mie_d = csr_wdata_o[MSTATUS_MIE];
        if (csr_we_o && (csr_waddr_o == CSR_MIE)) begin
            sh_meie_d = csr_wdata_o[MIE_MEIE];
            sh_mtie_d = csr_wdata_o[MIE_MTIE];
        end
    end

    // State register and shadows.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            sh_mie_q  <= 1'b0;
            sh_meie_q <= 1'b0;
            sh_mtie_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_mie_q  <= sh_mie_d;
            sh_meie_q <= sh_meie_d;
            sh_mtie_q <= sh_mtie_d;
        end
    end

    // Latch request context on acceptance and capture CSR read data.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            kind_q   <= KIND_EXC;
            pc_q     <= '0;
            cause_q  <= '0;
            tval_q   <= '0;
            tvec_q   <= '0;
            status_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && accept) begin
                kind_q <= acc_kind;
                unique case (acc_kind)
                    KIND_IRQ_EXT: begin
                        pc_q    <= irq_pc_i;
                        cause_q <= CAUSE_IRQ_EXT;
                        tval_q  <= '0;
                    end
                    KIND_IRQ_TIMER: begin
                        pc_q    <= irq_pc_i;
                        cause_q <= CAUSE_IRQ_TIMER;
                        tval_q  <= '0;
                    end
                    default: begin
                        pc_q    <= exc_pc_i;
                        cause_q <= exc_cause_i;
                        tval_q  <= exc_tval_i;
                    end
                endcase
            end
            if ((state_q == S_RD_TVEC) || (state_q == S_RD_EPC))
                tvec_q <= csr_rdata_i;
            if (state_q == S_RD_STAT)
                status_q <= csr_rdata_i;
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a behavioural csrfile model.
module tb_csr_trap_ctrl;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        exc_valid_i;
    logic [3:0]  exc_cause_i;
    logic [31:0] exc_pc_i;
    logic [31:0] exc_tval_i;
    logic        mret_valid_i;
    logic        irq_ext_i;
    logic        irq_timer_i;
    logic [31:0] irq_pc_i;
    logic        wb_csr_we_i;
    logic [11:0] wb_csr_waddr_i;
    logic [31:0] wb_csr_wdata_i;
    logic [31:0] csr_rdata_i;
    logic        busy_o;
    logic [11:0] csr_raddr_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    always #5 clk = ~clk;

    csr_trap_ctrl #(.XLEN(32)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n_i),
        .exc_valid_i      (exc_valid_i),
        .exc_cause_i      (exc_cause_i),
        .exc_pc_i         (exc_pc_i),
        .exc_tval_i       (exc_tval_i),
        .mret_valid_i     (mret_valid_i),
        .irq_ext_i        (irq_ext_i),
        .irq_timer_i      (irq_timer_i),
        .irq_pc_i         (irq_pc_i),
        .wb_csr_we_i      (wb_csr_we_i),
        .wb_csr_waddr_i   (wb_csr_waddr_i),
        .wb_csr_wdata_i   (wb_csr_wdata_i),
        .csr_rdata_i      (csr_rdata_i),
        .busy_o           (busy_o),
        .csr_raddr_o      (csr_raddr_o),
        .csr_we_o         (csr_we_o),
        .csr_waddr_o      (csr_waddr_o),
        .csr_wdata_o      (csr_wdata_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    // csrfile model: combinational read, own port muxed ahead of WB.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        f_we;
    logic [11:0] f_addr;
    logic [31:0] f_data;

    always_comb begin
        case (csr_raddr_o)
            CSR_MSTATUS: csr_rdata_i = m_mstatus;
            CSR_MIE:     csr_rdata_i = m_mie;
            CSR_MTVEC:   csr_rdata_i = m_mtvec;
            CSR_MEPC:    csr_rdata_i = m_mepc;
            CSR_MCAUSE:  csr_rdata_i = m_mcause;
            CSR_MTVAL:   csr_rdata_i = m_mtval;
            default:     csr_rdata_i = 32'h0;
        endcase
        f_we   = csr_we_o | wb_csr_we_i;
        f_addr = csr_we_o ? csr_waddr_o : wb_csr_waddr_i;
        f_data = csr_we_o ? csr_wdata_o : wb_csr_wdata_i;
    end

    always @(posedge clk) begin
        if (f_we) begin
            case (f_addr)
                CSR_MSTATUS: m_mstatus <= f_data;
                CSR_MIE:     m_mie     <= f_data;
                CSR_MTVEC:   m_mtvec   <= f_data;
                CSR_MEPC:    m_mepc    <= f_data;
                CSR_MCAUSE:  m_mcause  <= f_data;
                CSR_MTVAL:   m_mtval   <= f_data;
                default: ;
            endcase
        end
    end

    // Port-protocol watcher: idle port values zero, no same-address read/write.
    int viol = 0;
    always @(negedge clk) begin
        if (rst_n_i) begin
            if (!csr_we_o && (csr_wdata_o != 32'h0 || csr_waddr_o != 12'h0)) viol <= viol + 1;
            if (csr_we_o && (csr_raddr_o == csr_waddr_o)) viol <= viol + 1;
            if (!redirect_valid_o && redirect_pc_o != 32'h0) viol <= viol + 1;
            if (csr_we_o && !busy_o) viol <= viol + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk);
        wb_csr_we_i    = 1'b1;
        wb_csr_waddr_i = addr;
        wb_csr_wdata_i = data;
        @(posedge clk);
        #1;
        wb_csr_we_i    = 1'b0;
        wb_csr_waddr_i = 12'h0;
        wb_csr_wdata_i = 32'h0;
    endtask

    task automatic clear_reqs();
        exc_valid_i  = 1'b0;
        mret_valid_i = 1'b0;
        irq_ext_i    = 1'b0;
        irq_timer_i  = 1'b0;
    endtask

    int          busy_cnt, n_wr, redir_cnt, redir_cyc;
    logic [31:0] redir_pc;

    // Watch a fixed 12-cycle window after the accepting edge.
    task automatic collect(input bit poke);
        busy_cnt = 0; n_wr = 0; redir_cnt = 0; redir_cyc = 0; redir_pc = 32'h0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (csr_we_o) n_wr++;
            if (redirect_valid_o) begin
                redir_cnt++;
                redir_cyc = cyc;
                redir_pc  = redirect_pc_o;
            end
            if (poke && cyc == 2) begin
                exc_valid_i = 1'b1; mret_valid_i = 1'b1; irq_ext_i = 1'b1; irq_timer_i = 1'b1;
            end
            if (poke && cyc == 5) clear_reqs();
        end
    endtask

    // Requests already driven: let the next edge accept them, then drop them.
    task automatic fire(input bit poke);
        @(posedge clk);
        #1;
        clear_reqs();
        collect(poke);
    endtask

    typedef enum int {T_EXC, T_MRET, T_EXT, T_TMR} vkind_e;
    typedef struct {
        vkind_e      kind;
        logic [3:0]  cause;
        logic [31:0] pc, tval, mtvec, mstatus, mie, mepc;
        logic [31:0] e_mepc, e_mcause, e_mtval, e_mstatus, e_redir, e_redir_vec;
        int          e_cycles, e_writes;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_redir;
    int          idle_busy;

    initial begin
        //            kind   cause pc          tval          mtvec         mstatus       mie           mepc          e_mepc        e_mcause      e_mtval       e_mstatus     e_redir       e_redir_vec   cyc wr
        vecs[0] = '{T_EXC,  4'd2, 32'h100,    32'hDEADBEEF, 32'h80,       32'h8,        32'h0,        32'h0,        32'h100,      32'h2,        32'hDEADBEEF, 32'h1880,     32'h80,       32'h80,       7,  4};
        vecs[1] = '{T_MRET, 4'd0, 32'h0,      32'h0,        32'h80,       32'h1880,     32'h0,        32'h104,      32'h0,        32'h0,        32'h0,        32'h1888,     32'h104,      32'h104,      4,  1};
        vecs[2] = '{T_EXC,  4'd5, 32'h203,    32'h1234,     32'h302,      32'h0,        32'h0,        32'h0,        32'h200,      32'h5,        32'h1234,     32'h1800,     32'h300,      32'h300,      7,  4};
        vecs[3] = '{T_MRET, 4'd0, 32'h0,      32'h0,        32'h80,       32'h1800,     32'h0,        32'h457,      32'h0,        32'h0,        32'h0,        32'h1880,     32'h454,      32'h454,      4,  1};
        vecs[4] = '{T_EXT,  4'd0, 32'h400,    32'h0,        32'h201,      32'h8,        32'h800,      32'h0,        32'h400,      32'h8000000B, 32'h0,        32'h1880,     32'h200,      32'h22C,      7,  4};
        vecs[5] = '{T_TMR,  4'd0, 32'h50A,    32'h0,        32'h101,      32'hA,        32'h80,       32'h0,        32'h508,      32'h80000007, 32'h0,        32'h1882,     32'h100,      32'h11C,      7,  4};

        rst_n_i = 1'b0;
        clear_reqs();
        exc_cause_i = 4'h0; exc_pc_i = 32'h0; exc_tval_i = 32'h0; irq_pc_i = 32'h0;
        wb_csr_we_i = 1'b0; wb_csr_waddr_i = 12'h0; wb_csr_wdata_i = 32'h0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'b0, busy_o}, 32'h0);
        check("reset_we", {31'b0, csr_we_o}, 32'h0);
        check("reset_redirect", {31'b0, redirect_valid_o}, 32'h0);
        check("reset_raddr", {20'b0, csr_raddr_o}, 32'h0);
        check("reset_wdata", csr_wdata_o, 32'h0);
        check("reset_redir_pc", redirect_pc_o, 32'h0);
        rst_n_i = 1'b1;

        // Table-driven sequences.
        for (int i = 0; i < 6; i++) begin
            wb_write(CSR_MTVEC, vecs[i].mtvec);
            wb_write(CSR_MSTATUS, vecs[i].mstatus);
            wb_write(CSR_MIE, vecs[i].mie);
            wb_write(CSR_MEPC, vecs[i].mepc);
            wb_write(CSR_MTVAL, 32'hA5A5A5A5);
            wb_write(CSR_MCAUSE, 32'hFFFFFFFF);
            case (vecs[i].kind)
                T_EXC: begin
                    exc_valid_i = 1'b1; exc_cause_i = vecs[i].cause;
                    exc_pc_i = vecs[i].pc; exc_tval_i = vecs[i].tval; irq_pc_i = 32'hBAD0;
                end
                T_MRET: mret_valid_i = 1'b1;
                T_EXT: begin
                    irq_ext_i = 1'b1; irq_pc_i = vecs[i].pc; exc_pc_i = 32'hBAD0; exc_tval_i = 32'h77;
                end
                default: begin
                    irq_timer_i = 1'b1; irq_pc_i = vecs[i].pc; exc_pc_i = 32'hBAD0; exc_tval_i = 32'h77;
                end
            endcase
            fire(1'b0);
`ifdef MTVEC_VECTORED_EN
            exp_redir = vecs[i].e_redir_vec;
`else
            exp_redir = vecs[i].e_redir;
`endif
            check($sformatf("v%0d_redir_pc", i), redir_pc, exp_redir);
            check($sformatf("v%0d_redir_cycle", i), redir_cyc, vecs[i].e_cycles);
            check($sformatf("v%0d_redir_count", i), redir_cnt, 1);
            check($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].e_cycles);
            check($sformatf("v%0d_writes", i), n_wr, vecs[i].e_writes);
            check($sformatf("v%0d_mstatus", i), m_mstatus, vecs[i].e_mstatus);
            if (vecs[i].kind != T_MRET) begin
                check($sformatf("v%0d_mepc", i), m_mepc, vecs[i].e_mepc);
                check($sformatf("v%0d_mcause", i), m_mcause, vecs[i].e_mcause);
                check($sformatf("v%0d_mtval", i), m_mtval, vecs[i].e_mtval);
            end
            $display("vector %0d kind=%0d redirect=0x%08h cycles=%0d writes=%0d", i, vecs[i].kind, redir_pc, redir_cyc, n_wr);
        end

        // Timer interrupt gated by MTIE, then enabled through a WB write.
        wb_write(CSR_MSTATUS, 32'h8);
        wb_write(CSR_MIE, 32'h0);
        wb_write(CSR_MTVEC, 32'h100);
        wb_write(CSR_MTVAL, 32'h33);
        irq_timer_i = 1'b1;
        irq_pc_i    = 32'h600;
        idle_busy   = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy_o) idle_busy++;
        end
        check("gate_no_action", idle_busy, 0);
        wb_write(CSR_MIE, 32'h80);
        fire(1'b0);
        check("gate_mcause", m_mcause, 32'h80000007);
        check("gate_mtval", m_mtval, 32'h0);
        check("gate_mepc", m_mepc, 32'h600);
        check("gate_redir_pc", redir_pc, 32'h100);
        check("gate_redir_cycle", redir_cyc, 7);
        $display("timer gating: redirect=0x%08h mcause=0x%08h", redir_pc, m_mcause);

        // Simultaneous requests: exception wins; requests raised while busy are ignored.
        wb_write(CSR_MTVEC, 32'h80);
        wb_write(CSR_MSTATUS, 32'h8);
        wb_write(CSR_MIE, 32'h880);
        exc_valid_i = 1'b1; exc_cause_i = 4'd4; exc_pc_i = 32'h300; exc_tval_i = 32'h77;
        mret_valid_i = 1'b1; irq_ext_i = 1'b1; irq_pc_i = 32'h900;
        fire(1'b1);
        check("simul_mcause", m_mcause, 32'h4);
        check("simul_mepc", m_mepc, 32'h300);
        check("simul_mtval", m_mtval, 32'h77);
        check("simul_mstatus", m_mstatus, 32'h1880);
        check("simul_redir_pc", redir_pc, 32'h80);
        check("simul_redir_count", redir_cnt, 1);
        check("simul_busy_cycles", busy_cnt, 7);
        check("simul_writes", n_wr, 4);
        $display("simultaneous: redirect=0x%08h busy=%0d writes=%0d", redir_pc, busy_cnt, n_wr);

        // Reset asserted during WR_CAUSE aborts the trap and clears shadows.
        wb_write(CSR_MIE, 32'h880);
        wb_write(CSR_MSTATUS, 32'h8);
        wb_write(CSR_MTVAL, 32'h55);
        exc_valid_i = 1'b1; exc_cause_i = 4'd3; exc_pc_i = 32'h700; exc_tval_i = 32'h99;
        @(posedge clk);
        #1;
        clear_reqs();
        repeat (4) @(negedge clk);
        check("rst_mid_in_wr_cause", {20'b0, csr_waddr_o}, {20'b0, CSR_MCAUSE});
        rst_n_i = 1'b0;
        @(negedge clk);
        check("rst_mid_we", {31'b0, csr_we_o}, 32'h0);
        check("rst_mid_busy", {31'b0, busy_o}, 32'h0);
        check("rst_mid_redirect", {31'b0, redirect_valid_o}, 32'h0);
        rst_n_i = 1'b1;
        irq_ext_i = 1'b1; irq_timer_i = 1'b1;
        idle_busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy_o) idle_busy++;
        end
        clear_reqs();
        check("rst_mid_shadows_clear", idle_busy, 0);
        check("rst_mid_mtval_kept", m_mtval, 32'h55);
        $display("reset mid-sequence: busy_after=%0d mtval=0x%08h", idle_busy, m_mtval);

        @(negedge clk);
        check("port_protocol", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
